// File: rtl/snn_inference_ctrl.sv
// ---------------------------------------------------------------------------
// snn_inference_ctrl
//
// Sequencer between the AXI image buffer and the SNN core. A rising edge on
// NEW_IMAGE starts one inference. The controller clears the core, then runs
// NUM_STEPS scans of the pixel array. In each scan it emits one AER event
// (SPK_ADDR/SPK_VALID with SPK_READY handshake) for every pixel whose
// latency-coded spike falls in the current time step, followed by a one-cycle
// TICK. After the last step it waits for CORE_DONE, latches CORE_DIGIT into
// INFERED_DIGIT and raises COPROCESSOR_RDY for software polling.
//
// Optional feature, macro SNN_CTRL_TIMEOUT_EN: a watchdog in WAIT_CORE that
// reports digit 8'hFF with TIMEOUT_ERR after TIMEOUT_CYCLES cycles without
// CORE_DONE. Without the macro TIMEOUT_ERR is tied to 0.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   IMAGE             pixel array (stable while BUSY)
//   NEW_IMAGE         start request, rising edge triggers
//   SPK_ADDR/VALID    spike event output, SPK_READY accepts it
//   TICK              one-cycle end-of-time-step pulse
//   CORE_CLR          one-cycle pulse clearing neuron state
//   CORE_DONE/DIGIT   classification result from the core
//   COPROCESSOR_RDY   result valid, INFERED_DIGIT latched result
//   BUSY              high in any state other than IDLE and DONE
//   TIMEOUT_ERR       watchdog fired
// ---------------------------------------------------------------------------
module snn_inference_ctrl #(
    parameter int IMAGE_SIZE      = 256,
    parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
    parameter int PIXEL_MAX_VALUE = 255,
    parameter int PIXEL_BITS      = 8,
    parameter int NUM_STEPS       = 16
`ifdef SNN_CTRL_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES  = 65535
`endif
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic [IMAGE_SIZE-1:0][PIXEL_BITS-1:0] IMAGE,
    input  logic                                  NEW_IMAGE,
    output logic [IMAGE_SIZE_BITS-1:0]            SPK_ADDR,
    output logic                                  SPK_VALID,
    input  logic                                  SPK_READY,
    output logic                                  TICK,
    output logic                                  CORE_CLR,
    input  logic                                  CORE_DONE,
    input  logic [7:0]                            CORE_DIGIT,
    output logic                                  COPROCESSOR_RDY,
    output logic [7:0]                            INFERED_DIGIT,
    output logic                                  BUSY,
    output logic                                  TIMEOUT_ERR
);

    localparam int LEVELS    = PIXEL_MAX_VALUE + 1;
    localparam int STEP_SIZE = LEVELS / NUM_STEPS;
    localparam int STEP_BITS = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

    localparam logic [IMAGE_SIZE_BITS-1:0] LAST_IDX  = IMAGE_SIZE_BITS'(IMAGE_SIZE - 1);
    localparam logic [STEP_BITS-1:0]       LAST_STEP = STEP_BITS'(NUM_STEPS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SCAN,
        S_TICK,
        S_WAIT_CORE,
        S_DONE
    } state_t;

    state_t                     state;
    logic                       nimg_q;
    logic [IMAGE_SIZE_BITS-1:0] idx;
    logic [STEP_BITS-1:0]       step;
    logic [IMAGE_SIZE_BITS-1:0] spk_addr_q;
    logic                       spk_valid_q;
    logic                       tick_q;
    logic                       core_clr_q;
    logic                       rdy_q;
    logic [7:0]                 digit_q;
    logic                       busy_q;
    logic                       start;
    logic                       pixel_hit;

`ifdef SNN_CTRL_TIMEOUT_EN
    localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] wd_cnt;
    logic        timeout_q;
`endif

    // A pixel spikes in the step whose window [thr(step), thr(step-1)) holds
    // its value. The upper bound of step 0 is LEVELS, which every pixel is
    // below, so the step==0 special case falls out of the same compare.
    // Everything is done one bit wider than a pixel so LEVELS is representable.
    function automatic logic spike_hit(input logic [PIXEL_BITS-1:0] pix,
                                       input logic [STEP_BITS-1:0]  s);
        logic [PIXEL_BITS:0] upper;
        logic [PIXEL_BITS:0] lower;
        logic [PIXEL_BITS:0] p;
        upper = (PIXEL_BITS+1)'(LEVELS - int'(s) * STEP_SIZE);
        lower = (PIXEL_BITS+1)'(LEVELS - (int'(s) + 1) * STEP_SIZE);
        p     = {1'b0, pix};
        return (p != '0) && (p >= lower) && (p < upper);
    endfunction

    assign start     = NEW_IMAGE & ~nimg_q;
    assign pixel_hit = spike_hit(IMAGE[idx], step);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= S_IDLE;
            nimg_q      <= 1'b0;
            idx         <= '0;
            step        <= '0;
            spk_addr_q  <= '0;
            spk_valid_q <= 1'b0;
            tick_q      <= 1'b0;
            core_clr_q  <= 1'b0;
            rdy_q       <= 1'b0;
            digit_q     <= '0;
            busy_q      <= 1'b0;
`ifdef SNN_CTRL_TIMEOUT_EN
            wd_cnt      <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            nimg_q     <= NEW_IMAGE;
            tick_q     <= 1'b0;
            core_clr_q <= 1'b0;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_CLEAR;
                        core_clr_q <= 1'b1;
                        rdy_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        step       <= '0;
                        idx        <= '0;
`ifdef SNN_CTRL_TIMEOUT_EN
                        timeout_q  <= 1'b0;
`endif
                    end
                end

                S_CLEAR: begin
                    state <= S_SCAN;
                end

                S_SCAN: begin
                    // A pending event that the core has not taken stalls the scan.
                    if (!spk_valid_q || SPK_READY) begin
                        spk_valid_q <= pixel_hit;
                        if (pixel_hit) begin
                            spk_addr_q <= idx;
                        end
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= S_TICK;
                        end else begin
                            idx <= idx + IMAGE_SIZE_BITS'(1);
                        end
                    end
                end

                S_TICK: begin
                    // Drain the last event of the scan before marking the step.
                    if (spk_valid_q) begin
                        if (SPK_READY) begin
                            spk_valid_q <= 1'b0;
                        end
                    end else begin
                        tick_q <= 1'b1;
                        if (step == LAST_STEP) begin
                            state <= S_WAIT_CORE;
`ifdef SNN_CTRL_TIMEOUT_EN
                            wd_cnt <= '0;
`endif
                        end else begin
                            step  <= step + STEP_BITS'(1);
                            state <= S_SCAN;
                        end
                    end
                end

                S_WAIT_CORE: begin
                    if (CORE_DONE) begin
                        digit_q <= CORE_DIGIT;
                        rdy_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= S_DONE;
                    end
`ifdef SNN_CTRL_TIMEOUT_EN
                    else if (wd_cnt == WD_LAST) begin
                        digit_q   <= 8'hFF;
                        timeout_q <= 1'b1;
                        rdy_q     <= 1'b1;
                        busy_q    <= 1'b0;
                        state     <= S_DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 32'd1;
                    end
`endif
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign SPK_ADDR        = spk_addr_q;
    assign SPK_VALID       = spk_valid_q;
    assign TICK            = tick_q;
    assign CORE_CLR        = core_clr_q;
    assign COPROCESSOR_RDY = rdy_q;
    assign INFERED_DIGIT   = digit_q;
    assign BUSY            = busy_q;

`ifdef SNN_CTRL_TIMEOUT_EN
    assign TIMEOUT_ERR = timeout_q;
`else
    assign TIMEOUT_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_snn_inference_ctrl.sv
// ---------------------------------------------------------------------------
// tb_snn_inference_ctrl
//
// Directed sequence with randomized images and SPK_READY backpressure. The
// expected event stream is derived from each pixel's spike step
// ((PIXEL_MAX - pixel) / step width), listing per step the spiking pixel
// indices in ascending order followed by a tick marker (-1).
// ---------------------------------------------------------------------------
module tb_snn_inference_ctrl;

    localparam int NPIX  = 256;
    localparam int PMAX  = 255;
    localparam int NSTEP = 16;
    localparam int SSZ   = (PMAX + 1) / NSTEP;

    logic                 CLK;
    logic                 RST;
    logic [NPIX-1:0][7:0] image;
    logic                 NEW_IMAGE;
    logic [7:0]           SPK_ADDR;
    logic                 SPK_VALID;
    logic                 SPK_READY;
    logic                 TICK;
    logic                 CORE_CLR;
    logic                 CORE_DONE;
    logic [7:0]           CORE_DIGIT;
    logic                 COPROCESSOR_RDY;
    logic [7:0]           INFERED_DIGIT;
    logic                 BUSY;
    logic                 TIMEOUT_ERR;

    snn_inference_ctrl dut (
        .CLK             (CLK),
        .RST             (RST),
        .IMAGE           (image),
        .NEW_IMAGE       (NEW_IMAGE),
        .SPK_ADDR        (SPK_ADDR),
        .SPK_VALID       (SPK_VALID),
        .SPK_READY       (SPK_READY),
        .TICK            (TICK),
        .CORE_CLR        (CORE_CLR),
        .CORE_DONE       (CORE_DONE),
        .CORE_DIGIT      (CORE_DIGIT),
        .COPROCESSOR_RDY (COPROCESSOR_RDY),
        .INFERED_DIGIT   (INFERED_DIGIT),
        .BUSY            (BUSY),
        .TIMEOUT_ERR     (TIMEOUT_ERR)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Monitor state (written only by the monitor)
    int got[$];
    int tick_cyc[256];
    int nticks      = 0;
    int valid_seen  = 0;
    int overlap     = 0;
    int stall_viol  = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_addr  = '0;

    // Stimulus-side state
    int   exp_q[$];
    logic bp_en = 1'b0;
    int   start_cyc;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        SPK_READY = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            SPK_READY = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    always @(negedge CLK) begin
        if (SPK_VALID === 1'b1 && SPK_READY === 1'b1) got.push_back(int'(SPK_ADDR));
        if (SPK_VALID === 1'b1) valid_seen++;
        if (TICK === 1'b1) begin
            got.push_back(-1);
            if (nticks < 256) tick_cyc[nticks] = cyc;
            nticks++;
            if (SPK_VALID === 1'b1) overlap++;
        end
        if (prev_stall && (SPK_VALID !== 1'b1 || SPK_ADDR !== prev_addr)) stall_viol++;
        prev_stall = (SPK_VALID === 1'b1) && (SPK_READY === 1'b0);
        prev_addr  = SPK_ADDR;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick_clk();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic build_exp();
        exp_q.delete();
        for (int s = 0; s < NSTEP; s++) begin
            for (int i = 0; i < NPIX; i++) begin
                int p;
                p = int'(image[i]);
                if (p != 0 && (PMAX - p) / SSZ == s) exp_q.push_back(i);
            end
            exp_q.push_back(-1);
        end
    endtask

    task automatic compare_stream(input string tag, input int base);
        int n;
        int bad0;
        n    = got.size() - base;
        check({tag, "_len"}, n, exp_q.size());
        if (n > exp_q.size()) n = exp_q.size();
        bad0 = bad;
        for (int i = 0; i < n && bad == bad0; i++) begin
            check({tag, "_evt"}, got[base + i], exp_q[i]);
        end
    endtask

    task automatic start_image(input string tag);
        NEW_IMAGE = 1'b1;
        tick_clk();
        start_cyc = cyc;
        check({tag, "_clr_pulse"}, CORE_CLR, 1);
        check({tag, "_busy"}, BUSY, 1);
        check({tag, "_rdy_cleared"}, COPROCESSOR_RDY, 0);
        tick_clk();
        check({tag, "_clr_end"}, CORE_CLR, 0);
        NEW_IMAGE = 1'b0;
    endtask

    task automatic wait_ticks(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (nticks < target && n < budget) begin
            tick_clk();
            n++;
        end
        check({tag, "_ticks_reached"}, (nticks >= target), 1);
    endtask

    task automatic finish_core(input string tag, input logic [7:0] digit);
        repeat (3) tick_clk();
        check({tag, "_wait_rdy"}, COPROCESSOR_RDY, 0);
        check({tag, "_wait_busy"}, BUSY, 1);
        CORE_DIGIT = digit;
        CORE_DONE  = 1'b1;
        tick_clk();
        CORE_DONE  = 1'b0;
        check({tag, "_rdy"}, COPROCESSOR_RDY, 1);
        check({tag, "_digit"}, INFERED_DIGIT, digit);
        check({tag, "_idle_busy"}, BUSY, 0);
        check({tag, "_timeout_err"}, TIMEOUT_ERR, 0);
    endtask

    task automatic random_image();
        for (int i = 0; i < NPIX; i++) begin
            image[i] = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        end
    endtask

    initial begin
        int base;
        int t0;
        int v0;

        RST        = 1'b1;
        NEW_IMAGE  = 1'b0;
        CORE_DONE  = 1'b0;
        CORE_DIGIT = '0;
        image      = '0;
        repeat (3) tick_clk();
        check("rst_spk_valid", SPK_VALID, 0);
        check("rst_spk_addr", SPK_ADDR, 0);
        check("rst_tick", TICK, 0);
        check("rst_core_clr", CORE_CLR, 0);
        check("rst_rdy", COPROCESSOR_RDY, 0);
        check("rst_digit", INFERED_DIGIT, 0);
        check("rst_busy", BUSY, 0);
        check("rst_timeout", TIMEOUT_ERR, 0);
        RST = 1'b0;
        tick_clk();

        // Single-pixel levels: 3 -> step 0, 57 -> step 10, 100 -> step 15
        image      = '0;
        image[3]   = 8'd255;
        image[57]  = 8'd81;
        image[100] = 8'd3;
        build_exp();
        check("levels_model_len", exp_q.size(), 19);
        base = got.size();
        t0   = nticks;
        start_image("levels");
        wait_ticks("levels", t0 + 16, 6000);
        finish_core("levels", 8'd5);
        compare_stream("levels", base);

        // All-zero image, restart from DONE, ignored NEW_IMAGE edge and CORE_DONE in SCAN
        image = '0;
        build_exp();
        base = got.size();
        t0   = nticks;
        v0   = valid_seen;
        start_image("zero");
        repeat (50) tick_clk();
        NEW_IMAGE  = 1'b1;
        CORE_DONE  = 1'b1;
        CORE_DIGIT = 8'd9;
        tick_clk();
        CORE_DONE  = 1'b0;
        check("zero_busy_after_edge", BUSY, 1);
        check("zero_no_clr_on_busy_start", CORE_CLR, 0);
        repeat (5) tick_clk();
        NEW_IMAGE = 1'b0;
        wait_ticks("zero", t0 + 16, 6000);
        check("zero_tick1_time", tick_cyc[t0] - start_cyc, 258);
        check("zero_tick16_time", tick_cyc[t0 + 15] - start_cyc, 4113);
        finish_core("zero", 8'd7);
        compare_stream("zero", base);
        check("zero_no_valid", valid_seen - v0, 0);

        // Random full image, SPK_READY high, then with backpressure
        random_image();
        build_exp();
        base = got.size();
        t0   = nticks;
        start_image("rand");
        wait_ticks("rand", t0 + 16, 20000);
        finish_core("rand", 8'($urandom_range(0, 9)));
        compare_stream("rand", base);

        base  = got.size();
        t0    = nticks;
        bp_en = 1'b1;
        start_image("bp");
        wait_ticks("bp", t0 + 16, 20000);
        bp_en = 1'b0;
        finish_core("bp", 8'd3);
        compare_stream("bp", base);
        check("stall_addr_hold", stall_viol, 0);
        check("tick_with_valid", overlap, 0);

        // Reset in step 7
        random_image();
        t0 = nticks;
        start_image("abort");
        wait_ticks("abort", t0 + 7, 6000);
        repeat (20) tick_clk();
        RST = 1'b1;
        tick_clk();
        check("abort_spk_valid", SPK_VALID, 0);
        check("abort_spk_addr", SPK_ADDR, 0);
        check("abort_tick", TICK, 0);
        check("abort_rdy", COPROCESSOR_RDY, 0);
        check("abort_digit", INFERED_DIGIT, 0);
        check("abort_busy", BUSY, 0);
        RST = 1'b0;
        t0 = nticks;
        v0 = valid_seen;
        repeat (600) tick_clk();
        check("abort_no_ticks", nticks - t0, 0);
        check("abort_no_valid", valid_seen - v0, 0);
        start_image("after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
